ux607_pin_out_shaper: RTL and testbench
=======================================

# ux607_pin_out_shaper

Output-side companion to the GPIO input deglitch path. It takes a requested pin level from the peripheral register logic and drives the registered pad output. Every output level is held for a programmable minimum number of cycles, so short pulses are stretched, never lost. A far-end receiver with a 2-flop synchronizer and 2-sample deglitch therefore always sees each level. Bounced requests that collapse during a hold window are flagged to software.

## Interface
Parameters:
- CNT_W, 8: width of the hold counter and `io_hold`.
- RESET_LEVEL, 1'b0: level of `io_q` during and after reset.

Ports:
- clock  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-high.
- io_d  input  1  requested pin level.
- io_en  input  1  output update enable; low freezes `io_q`.
- io_hold  input  CNT_W  minimum hold length H in cycles; 0 is treated as 1.
- io_clr_dropped  input  1  one-cycle pulse that clears `io_dropped`.
- io_q  output  1  registered pad output level.
- io_busy  output  1  high while a hold window is running (`cnt != 0`).
- io_dropped  output  1  sticky flag: a requested level change was lost.

## Operation
- State: `q` (drives `io_q`), `cnt` (CNT_W bits), `seen` (1 bit), `dropped` (1 bit).
- Heff = max(`io_hold`, 1). Sample `io_hold` only at a toggle edge; changing `io_hold` mid-window has no effect on the running window.
- Two states:
  - IDLE (`cnt == 0`)
  - HOLD (`cnt != 0`)
- Behaviour in IDLE, at each edge:
  - If `io_en && io_d != q`:
    - `q <= io_d`
    - `cnt <= Heff-1`
    - `seen <= 0`
    - Go to HOLD if Heff > 1.
  - Otherwise:
    - If `seen && io_d == q`, set `dropped`.
    - `seen <= 0`.
- Behaviour in HOLD, at each edge:
  - `cnt <= cnt-1`.
  - If `io_d != q`, set `seen`.
  - `q` does not change.
- Hold-window expiry:
  - The first IDLE edge after HOLD applies `io_d` as it is at that edge, not any intermediate value.
  - A pending opposite level toggles `q` immediately, and that toggle does not set `dropped`.
- `io_en` low:
  - `q` is frozen and `cnt` keeps decrementing.
  - `seen`/`dropped` update as above; only toggling is suppressed.
- `io_dropped`:
  - Set-dominant: set and `io_clr_dropped` on the same edge leave it at 1.
  - Otherwise `io_clr_dropped` clears it.
- Counter arithmetic: unsigned, never wraps. Decrement only when nonzero; load only in IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - `io_q` = RESET_LEVEL
  - `io_busy` = 0
  - `io_dropped` = 0
  - internal `cnt` = 0, `seen` = 0
- Reset asserted mid-hold aborts the window. On release the block is in IDLE, with the first toggle possible at the first edge after deassertion.
- Latency: a change on `io_d` in IDLE appears on `io_q` after 1 edge.
- Toggle at edge k:
  - `io_q` is stable from after edge k through edge k+Heff-1.
  - The earliest next toggle is edge k+Heff.
  - `io_busy` is high after edges k..k+Heff-2; it stays 0 when Heff = 1.
- Heff = 1: `io_q` is `io_d` delayed by one register, with no stretching.
- All outputs come directly from flops; there is no combinational path from input to output.

## Structure
- Shared header `ux607_pin_defines`: default CNT_W and the RESET_LEVEL constants, shared with the GPIO input path and the pin-control registers.
- One natural sub-module, `ux607_hold_counter`: a loadable down-counter with a zero flag (inputs load/value, output `busy`). The toggle, seen and dropped logic stays in the top level.
- Total RTL: about 150 lines.

## Test plan
- Reset: assert `reset` with RESET_LEVEL=0 mid-hold, with `io_d`=1 → `io_q`=0, `io_busy`=0 and `io_dropped`=0 immediately. After release, `io_q`=1 one edge later.
- Stretch: H=4, single-cycle `io_d`=1 sampled at edge 10 → `io_q`=1 after edges 10..13, 0 after edge 14. `io_busy` high after edges 10..12. `io_dropped` stays 0.
- Bounce: H=4, `io_d`=1 at edge 10, 0 at edge 11, 1 at edges 12 onward → `io_q` stays 1 and `io_dropped`=1 after edge 14. Then `io_clr_dropped` at edge 20 → 0 after edge 20.
- Set/clear collision: repeat the bounce with `io_clr_dropped` high at edge 14 → `io_dropped`=1.
- Enable: `io_en`=0, `io_d` toggled → `io_q` unchanged. Raise `io_en` with `cnt`=0 and `io_d`≠`io_q` → `io_q` follows one edge later.
- H=0: `io_d` alternates every cycle → `io_q` equals `io_d` delayed one cycle, `io_busy` stays 0, `io_dropped` stays 0.

Source files
------------

// File: rtl/ux607_pin_defines_pkg.sv
// Pin-path constants shared by the GPIO input deglitch path, the output shaper
// and the pin-control registers.
package ux607_pin_defines_pkg;

    localparam int   DEF_CNT_W      = 8;
    localparam logic PIN_RESET_LOW  = 1'b0;
    localparam logic PIN_RESET_HIGH = 1'b1;

    typedef enum logic {
        PIN_IDLE = 1'b0,
        PIN_HOLD = 1'b1
    } pin_state_e;

endpackage

// File: rtl/ux607_hold_counter.sv
// Loadable down-counter that stops at zero; busy_o is a registered "count != 0".
module ux607_hold_counter
    import ux607_pin_defines_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // busy is precomputed from the next count so the output comes straight from a flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ux607_pin_out_shaper.sv
// Pad output shaper: each driven level is held for at least max(io_hold,1) cycles,
// and a request that bounces back to the held level during the window is flagged.
module ux607_pin_out_shaper
    import ux607_pin_defines_pkg::*;
#(
    parameter int   CNT_W       = DEF_CNT_W,
    parameter logic RESET_LEVEL = PIN_RESET_LOW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_d,
    input  logic             io_en,
    input  logic [CNT_W-1:0] io_hold,
    input  logic             io_clr_dropped,
    output logic             io_q,
    output logic             io_busy,
    output logic             io_dropped
);

    logic             q_q, q_d;
    logic             seen_q, seen_d;
    logic             dropped_q, dropped_d;
    logic             busy;
    logic             toggle;
    logic             drop_set;
    logic [CNT_W-1:0] heff;
    logic [CNT_W-1:0] load_val;
    pin_state_e       state;

    assign state    = busy ? PIN_HOLD : PIN_IDLE;
    assign heff     = (io_hold == '0) ? CNT_W'(1) : io_hold;
    assign load_val = heff - 1'b1;
    assign toggle   = (state == PIN_IDLE) && io_en && (io_d != q_q);

    always_comb begin
        q_d      = q_q;
        seen_d   = seen_q;
        drop_set = 1'b0;
        case (state)
            PIN_IDLE: begin
                if (toggle) begin
                    q_d    = io_d;
                    seen_d = 1'b0;
                end else begin
                    // a change was seen in the window but the request is back at q
                    drop_set = seen_q && (io_d == q_q);
                    seen_d   = 1'b0;
                end
            end
            default: begin
                if (io_d != q_q) begin
                    seen_d = 1'b1;
                end
            end
        endcase
        if (drop_set) begin
            dropped_d = 1'b1;
        end else if (io_clr_dropped) begin
            dropped_d = 1'b0;
        end else begin
            dropped_d = dropped_q;
        end
    end

    ux607_hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clock   (clock),
        .reset   (reset),
        .load_i  (toggle),
        .value_i (load_val),
        .busy_o  (busy)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q       <= RESET_LEVEL;
            seen_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            seen_q    <= seen_d;
            dropped_q <= dropped_d;
        end
    end

    assign io_q       = q_q;
    assign io_busy    = busy;
    assign io_dropped = dropped_q;

endmodule

// File: tb/tb_ux607_pin_out_shaper.sv
// Bench for ux607_pin_out_shaper: directed scenarios plus random traffic,
// all compared against an edge-timed reference of the hold-window rules.
module tb_ux607_pin_out_shaper;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_d = 1'b0;
    logic       io_en = 1'b1;
    logic [7:0] io_hold = 8'd1;
    logic       io_clr_dropped = 1'b0;
    logic       io_q, io_busy, io_dropped;

    int total = 0;
    int bad = 0;

    // reference: level, edge of last toggle and its window length
    logic m_q, m_seen, m_drop;
    int   edge_n, tog_edge, tog_len;

    ux607_pin_out_shaper #(
        .CNT_W       (8),
        .RESET_LEVEL (1'b0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_d           (io_d),
        .io_en          (io_en),
        .io_hold        (io_hold),
        .io_clr_dropped (io_clr_dropped),
        .io_q           (io_q),
        .io_busy        (io_busy),
        .io_dropped     (io_dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q      = 1'b0;
        m_seen   = 1'b0;
        m_drop   = 1'b0;
        tog_edge = 0;
        tog_len  = 0;
    endtask

    task automatic model_edge(input logic d, input logic en, input logic [7:0] h, input logic clr);
        logic set;
        set = 1'b0;
        edge_n++;
        if (edge_n >= tog_edge + tog_len) begin
            if (en && d != m_q) begin
                m_q      = d;
                tog_edge = edge_n;
                tog_len  = (h == 0) ? 1 : int'(h);
                m_seen   = 1'b0;
            end else begin
                set    = m_seen && (d == m_q);
                m_seen = 1'b0;
            end
        end else if (d != m_q) begin
            m_seen = 1'b1;
        end
        if (set) m_drop = 1'b1;
        else if (clr) m_drop = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 32'(io_q), 32'(m_q));
        chk({tag, ".busy"}, 32'(io_busy), 32'(edge_n < tog_edge + tog_len - 1));
        chk({tag, ".dropped"}, 32'(io_dropped), 32'(m_drop));
    endtask

    task automatic step(input string tag, input logic d, input logic en,
                        input logic [7:0] h, input logic clr);
        io_d = d;
        io_en = en;
        io_hold = h;
        io_clr_dropped = clr;
        @(posedge clock);
        model_edge(d, en, h, clr);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_q"}, 32'(io_q), 32'd0);
        chk({tag, ".rst_busy"}, 32'(io_busy), 32'd0);
        chk({tag, ".rst_dropped"}, 32'(io_dropped), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle_low(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b1, 8'd1, 1'b0);
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        #2;
        chk("por_q", 32'(io_q), 32'd0);
        chk("por_busy", 32'(io_busy), 32'd0);
        chk("por_dropped", 32'(io_dropped), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // stretch: one-cycle high request with H=4
        idle_low(3);
        step("stretch", 1'b1, 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stretch", 1'b0, 1'b1, 8'd4, 1'b0);
            chk("stretch_hold_q", 32'(io_q), 32'd1);
        end
        step("stretch", 1'b0, 1'b1, 8'd4, 1'b0);
        chk("stretch_end_q", 32'(io_q), 32'd0);
        chk("stretch_no_drop", 32'(io_dropped), 32'd0);

        // bounce: 1,0,1,1,... inside the window gets flagged
        idle_low(5);
        step("bounce", 1'b1, 1'b1, 8'd4, 1'b0);
        step("bounce", 1'b0, 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 3; i++) step("bounce", 1'b1, 1'b1, 8'd4, 1'b0);
        chk("bounce_q", 32'(io_q), 32'd1);
        chk("bounce_dropped", 32'(io_dropped), 32'd1);
        for (int i = 0; i < 3; i++) step("bounce", 1'b1, 1'b1, 8'd4, 1'b0);
        step("clear", 1'b1, 1'b1, 8'd4, 1'b1);
        chk("clear_dropped", 32'(io_dropped), 32'd0);

        // set and clear on the same edge: set wins
        idle_low(5);
        step("coll", 1'b1, 1'b1, 8'd4, 1'b0);
        step("coll", 1'b0, 1'b1, 8'd4, 1'b0);
        step("coll", 1'b1, 1'b1, 8'd4, 1'b0);
        step("coll", 1'b1, 1'b1, 8'd4, 1'b0);
        step("coll", 1'b1, 1'b1, 8'd4, 1'b1);
        chk("coll_dropped", 32'(io_dropped), 32'd1);
        step("coll", 1'b1, 1'b1, 8'd4, 1'b1);
        chk("coll_cleared", 32'(io_dropped), 32'd0);

        // enable low freezes q; raising it lets q follow one edge later
        for (int i = 0; i < 4; i++) step("en_off", 1'(i), 1'b0, 8'd2, 1'b0);
        chk("en_frozen_q", 32'(io_q), 32'd1);
        step("en_off", 1'b0, 1'b0, 8'd2, 1'b0);
        step("en_on", 1'b0, 1'b1, 8'd2, 1'b0);
        chk("en_follow_q", 32'(io_q), 32'd0);

        // H=0: plain one-register delay, never busy
        for (int i = 0; i < 12; i++) begin
            step("h0", 1'(i & 1), 1'b1, 8'd0, 1'b0);
            chk("h0_q", 32'(io_q), 32'(i & 1));
            chk("h0_busy", 32'(io_busy), 32'd0);
        end

        // reset mid-hold with io_d high, then q follows one edge after release
        step("rst_mid", 1'b0, 1'b1, 8'd6, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 8'd6, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 8'd6, 1'b0);
        io_d = 1'b1;
        pulse_reset("rst_mid");
        step("rst_rel", 1'b1, 1'b1, 8'd6, 1'b0);
        chk("rst_rel_q", 32'(io_q), 32'd1);

        // random traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] h;
            h = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) h = 8'($urandom_range(6, 255));
            if ($urandom_range(0, 299) == 0) pulse_reset("rnd");
            step("rnd", 1'($urandom), ($urandom_range(0, 7) != 0),
                 h, ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
